// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM state encoding and sizing helper
// for the handshaked sequential ALU (alu_seq).
package alu_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_ADD = 3'b000;
    localparam op_t OP_SUB = 3'b001;
    localparam op_t OP_DIV = 3'b010;
    localparam op_t OP_MUL = 3'b011;
    localparam op_t OP_AND = 3'b100;
    localparam op_t OP_OR  = 3'b101;
    localparam op_t OP_NOT = 3'b110;
    localparam op_t OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to count 0..w iterations.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: issue-side request and writeback-side result bundle.
// master = requester/consumer side, slave = the ALU.
interface alu_seq_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    op_t              opcode;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_ovf;
    logic             flag_dbz;

    modport master (
        output in_valid, opcode, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result, result_hi,
        input  flag_zero, flag_carry, flag_ovf, flag_dbz
    );

    modport slave (
        input  in_valid, opcode, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result, result_hi,
        output flag_zero, flag_carry, flag_ovf, flag_dbz
    );
endinterface

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: iterative one-bit-per-cycle unsigned shift-add
// multiply / restoring divide.
// Ports: clk, rst (sync high); start/is_div/a/b load an operation;
// done pulses in the last iteration cycle, with lo/hi showing the
// final value that the register pair takes at that edge
// (product {hi,lo}, or quotient lo / remainder hi).
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0]    cnt;
    logic             active;
    logic             div_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;
    logic             last;

    // Multiply: lo holds the multiplier, shifted out LSB first while
    // partial-product bits shift in from the top.
    // Divide: lo holds the dividend, shifted out MSB first into the
    // remainder while quotient bits shift in at the bottom.
    always_comb begin
        sum  = '0;
        shl  = '0;
        hi_n = hi_q;
        lo_n = lo_q;
        if (div_q) begin
            shl = {hi_q, lo_q[WIDTH-1]};
            if (shl >= {1'b0, b_q}) begin
                sum  = shl - {1'b0, b_q};
                lo_n = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                sum  = shl;
                lo_n = {lo_q[WIDTH-2:0], 1'b0};
            end
            hi_n = sum[WIDTH-1:0];
        end else begin
            if (lo_q[0]) begin
                sum = {1'b0, hi_q} + {1'b0, b_q};
            end else begin
                sum = {1'b0, hi_q};
            end
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign last = active && (cnt == CW'(WIDTH - 1));
    assign done = last;
    assign lo   = lo_n;
    assign hi   = hi_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
            div_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            div_q  <= is_div;
            hi_q   <= '0;
            lo_q   <= a;
            b_q    <= b;
        end else if (active) begin
            hi_q <= hi_n;
            lo_q <= lo_n;
            if (last) begin
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU, one operation in flight.
// Ports: clk, rst (sync high), bus (alu_seq_if.slave): issue side
// in_valid/in_ready/opcode/operand_a/operand_b, writeback side
// out_valid/out_ready/result/result_hi and zero/carry/ovf/dbz flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    localparam int M = WIDTH - 1;

    state_t           state;
    state_t           state_n;
    op_t              op_q;
    logic             in_rdy;
    logic             accept;
    logic             needs_md;
    logic             start_md;
    logic             md_done;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;

    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_c;
    logic             sc_o;
    logic             sc_d;

    logic             ld;
    logic [WIDTH-1:0] ld_res;
    logic [WIDTH-1:0] ld_hi;
    logic             ld_c;
    logic             ld_o;
    logic             ld_d;
    logic             ld_z;

    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] hi_q;
    logic             z_q;
    logic             c_q;
    logic             o_q;
    logic             d_q;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    assign a = bus.operand_a;
    assign b = bus.operand_b;

    assign in_rdy   = (state == ST_IDLE) && !rst;
    assign accept   = bus.in_valid && in_rdy;
    assign needs_md = (bus.opcode == OP_MUL) ||
                      ((bus.opcode == OP_DIV) && (b != '0));

    // Single-cycle results; divide-by-zero also resolves here.
    always_comb begin
        add_w  = {1'b0, a} + {1'b0, b};
        sub_w  = {1'b0, a} - {1'b0, b};
        sc_res = '0;
        sc_hi  = '0;
        sc_c   = 1'b0;
        sc_o   = 1'b0;
        sc_d   = 1'b0;
        unique case (bus.opcode)
            OP_ADD: begin
                sc_res = add_w[WIDTH-1:0];
                sc_c   = add_w[WIDTH];
                sc_o   = (a[M] == b[M]) && (add_w[M] != a[M]);
            end
            OP_SUB: begin
                sc_res = sub_w[WIDTH-1:0];
                sc_c   = sub_w[WIDTH];
                sc_o   = (a[M] != b[M]) && (sub_w[M] != a[M]);
            end
            OP_DIV: begin
                sc_res = '1;
                sc_hi  = a;
                sc_d   = 1'b1;
            end
            OP_MUL: begin
                sc_res = '0;
            end
            OP_AND: sc_res = a & b;
            OP_OR:  sc_res = a | b;
            OP_NOT: sc_res = ~a;
            OP_XOR: sc_res = a ^ b;
            default: sc_res = '0;
        endcase
    end

    alu_seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (start_md),
        .is_div (bus.opcode == OP_DIV),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .lo     (md_lo),
        .hi     (md_hi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        start_md = 1'b0;
        ld       = 1'b0;
        ld_res   = sc_res;
        ld_hi    = sc_hi;
        ld_c     = sc_c;
        ld_o     = sc_o;
        ld_d     = sc_d;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (needs_md) begin
                        state_n  = ST_BUSY;
                        start_md = 1'b1;
                    end else begin
                        state_n = ST_DONE;
                        ld      = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (md_done) begin
                    state_n = ST_DONE;
                    ld      = 1'b1;
                    ld_res  = md_lo;
                    ld_hi   = md_hi;
                    ld_c    = 1'b0;
                    ld_d    = 1'b0;
                    ld_o    = (op_q == OP_MUL) && (md_hi != '0);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign ld_z = (ld_res == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= OP_ADD;
            res_q <= '0;
            hi_q  <= '0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            o_q   <= 1'b0;
            d_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= bus.opcode;
            end
            if (ld) begin
                res_q <= ld_res;
                hi_q  <= ld_hi;
                z_q   <= ld_z;
                c_q   <= ld_c;
                o_q   <= ld_o;
                d_q   <= ld_d;
            end
        end
    end

    assign bus.in_ready   = in_rdy;
    assign bus.out_valid  = (state == ST_DONE);
    assign bus.result     = res_q;
    assign bus.result_hi  = hi_q;
    assign bus.flag_zero  = z_q;
    assign bus.flag_carry = c_q;
    assign bus.flag_ovf   = o_q;
    assign bus.flag_dbz   = d_q;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the team's 8-bit combinational ALU. Executes the same 3-bit opcode set at WIDTH bits:
- single-cycle logic and add/sub ops
- iterative (one bit per cycle) multiply and divide, producing a double-width product or quotient plus remainder
- status flags on every result

Sits between an issue stage (valid/ready) and a writeback stage (valid/ready), with one operation in flight at a time.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operation request valid.
in_ready  out  1  block can accept an operation.
opcode  in  3  000 ADD, 001 SUB, 010 DIV, 011 MUL, 100 AND, 101 OR, 110 NOT A, 111 XOR.
operand_a  in  WIDTH  first operand (unsigned for DIV/MUL).
operand_b  in  WIDTH  second operand.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
result  out  WIDTH  primary result.
result_hi  out  WIDTH  MUL upper product bits; DIV remainder; 0 otherwise.
flag_zero  out  1  result == 0 (low word only).
flag_carry  out  1  ADD carry-out; SUB borrow (A < B unsigned); 0 otherwise.
flag_ovf  out  1  ADD/SUB signed two's-complement overflow; MUL result_hi != 0; 0 otherwise.
flag_dbz  out  1  DIV with operand_b == 0.

Behaviour:
- States: IDLE, BUSY, DONE.
- in_ready = (state == IDLE) && !rst. in_ready is low in BUSY and DONE.
- Accept: in_valid && in_ready in cycle N. Latch opcode and operands. Later changes on the inputs are ignored.
- Single-cycle ops (ADD, SUB, AND, OR, NOT, XOR): IDLE -> DONE. out_valid is high in cycle N+1.
- XOR is operand_a ^ operand_b.
- NOT is ~operand_a; operand_b is ignored.
- ADD/SUB wrap modulo 2^WIDTH.
- MUL:
  - IDLE -> BUSY for exactly WIDTH shift-add cycles, then DONE. out_valid is high in cycle N+WIDTH+1.
  - {result_hi, result} = full 2*WIDTH-bit unsigned product.
- DIV, operand_b != 0:
  - Restoring division, WIDTH cycles in BUSY. Same latency as MUL.
  - result = quotient, result_hi = remainder.
- DIV, operand_b == 0:
  - No BUSY phase. IDLE -> DONE, latency 1.
  - result = all ones, result_hi = operand_a, flag_dbz = 1.
- DONE:
  - out_valid = 1. result, result_hi and all flags are held stable until out_ready.
  - out_valid && out_ready: -> IDLE next cycle, out_valid drops, in_ready rises.
  - Minimum spacing between accepts = latency + 1 cycles.
- Flags are computed from the final result and registered together with it. They are valid only while out_valid is high.
- Reset, any state (including mid-BUSY): next cycle state = IDLE and the in-flight op is discarded without ever asserting out_valid. Reset values:
  - out_valid = 0
  - result = 0, result_hi = 0
  - all flags = 0
  - iteration counter = 0
- in_ready is 0 during any cycle with rst high. It is 1 from the first cycle after rst deasserts.
- in_valid asserted during BUSY/DONE is not accepted. The requester must hold it until in_ready is high.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_ADD … OP_XOR, 3 bits)
  - state typedef/encoding (IDLE, BUSY, DONE)
  - counter width function clog2(WIDTH+1)
- One sub-module: alu_seq_muldiv, the iterative multiply/divide datapath. It takes start, is_div, a, b and returns done, lo, hi. It owns the shift registers and the iteration counter.
- alu_seq keeps the FSM, the single-cycle ops, flag generation and the output registers.

Test Plan:
1. ADD A=200, B=100, out_ready=1 -> out_valid at N+1, result=44, carry=1, ovf=0, zero=0. Then SUB A=5, B=7 -> result=254, carry=1, ovf=0.
2. MUL A=25, B=20 -> out_valid at N+9, result=0xF4, result_hi=0x01, ovf=1. Also MUL A=0, B=77 -> result=0, zero=1, ovf=0.
3. DIV A=200, B=7 -> result=28, result_hi=4, dbz=0, latency 9. DIV A=200, B=0 -> latency 1, result=0xFF, result_hi=200, dbz=1.
4. Backpressure: XOR A=0xA5, B=0x0F with out_ready=0 for 5 cycles -> result=0xAA stable and out_valid=1 throughout; in_ready=0; a new in_valid is not accepted until one cycle after out_ready=1.
5. Reset mid-DIV: rst=1 on cycle 4 of BUSY -> next cycle out_valid=0, outputs=0, in_ready=1 after rst drops; the aborted result never appears. A following ADD 1+1 returns 2.
6. WIDTH=16 instance: MUL 0xFFFF * 0xFFFF -> result=0x0001, result_hi=0xFFFE, latency 17. ADD 0x7FFF+1 -> result=0x8000, ovf=1, carry=0.
